// File: rtl/clk_div_monitor_pkg.sv
// Shared definitions for the divided-clock monitor: FSM encoding and timeout scaling.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  // Stuck timeout is this many expected periods without a rising edge.
  localparam int TIMEOUT_MULT = 2;

endpackage

// File: rtl/clk_div_monitor_edge_det.sv
// Registered sample of a clk-domain signal with combinational rise/fall strobes.
module edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig_q_reg <= 1'b0;
    end else begin
      sig_q_reg <= sig;
    end
  end

  assign rise = sig & ~sig_q_reg;
  assign fall = ~sig & sig_q_reg;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock, tracks lock against the
// expected ratio and raises sticky period, duty and stuck errors.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int EXP_DIV  = 6,
  parameter int EXP_HIGH = 3,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             div_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_stuck
);

  localparam int                 MATCH_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   EXP_DIV_C  = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0]   EXP_HIGH_C = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0]   STUCK_LIM  = CNT_W'(TIMEOUT_MULT * EXP_DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [MATCH_W-1:0] LOCK_C     = MATCH_W'(LOCK_CNT);

  logic               rise;
  logic               fall;
  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   per_cnt_reg;
  logic [CNT_W-1:0]   hi_cnt_reg;
  logic               hi_active_reg;
  logic [MATCH_W-1:0] match_cnt_reg;
  logic [CNT_W-1:0]   period_reg;
  logic [CNT_W-1:0]   high_reg;
  logic               meas_valid_reg;
  logic               locked_reg;
  logic               err_period_reg;
  logic               err_duty_reg;
  logic               err_stuck_reg;
  logic               meas_fire;
  logic               stuck_fire;
  logic               per_ok;
  logic               hi_ok;

  edge_det u_edge_det (
    .clk  (clk),
    .rstn (rstn),
    .sig  (div_in),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (stuck_fire) begin
      state_next = ST_IDLE;
    end else if (rise) begin
      case (state_reg)
        ST_IDLE:  state_next = ST_ARM;
        ST_ARM:   state_next = ST_TRACK;
        ST_TRACK: state_next = ST_TRACK;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // The rise that leaves ARM closes the first full period, so it is reported.
  always_comb begin
    meas_fire  = rise && (state_reg != ST_IDLE);
    stuck_fire = !rise && (per_cnt_reg == STUCK_LIM);
    per_ok     = (per_cnt_reg == EXP_DIV_C);
    hi_ok      = (hi_cnt_reg == EXP_HIGH_C);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      per_cnt_reg   <= '0;
      hi_cnt_reg    <= '0;
      hi_active_reg <= 1'b0;
    end else begin
      if (rise) begin
        per_cnt_reg <= CNT_W'(1);
      end else if (per_cnt_reg != CNT_MAX) begin
        per_cnt_reg <= per_cnt_reg + 1'b1;
      end

      if (rise) begin
        hi_cnt_reg <= CNT_W'(1);
      end else if (hi_active_reg && !fall && (hi_cnt_reg != CNT_MAX)) begin
        hi_cnt_reg <= hi_cnt_reg + 1'b1;
      end

      if (rise) begin
        hi_active_reg <= 1'b1;
      end else if (fall) begin
        hi_active_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_reg     <= '0;
      high_reg       <= '0;
      meas_valid_reg <= 1'b0;
      match_cnt_reg  <= '0;
      locked_reg     <= 1'b0;
      err_period_reg <= 1'b0;
      err_duty_reg   <= 1'b0;
      err_stuck_reg  <= 1'b0;
    end else begin
      meas_valid_reg <= meas_fire;
      if (meas_fire) begin
        period_reg <= per_cnt_reg;
        high_reg   <= hi_cnt_reg;
      end

      if (stuck_fire) begin
        match_cnt_reg <= '0;
        locked_reg    <= 1'b0;
      end else if (meas_fire) begin
        if (per_ok && hi_ok) begin
          if (match_cnt_reg != LOCK_C) begin
            match_cnt_reg <= match_cnt_reg + 1'b1;
          end
          locked_reg <= (match_cnt_reg >= LOCK_C - MATCH_W'(1));
        end else begin
          match_cnt_reg <= '0;
          locked_reg    <= 1'b0;
        end
      end

      // A new error in the same cycle as err_clr keeps its flag set.
      err_period_reg <= (meas_fire && !per_ok) || (err_period_reg && !err_clr);
      err_duty_reg   <= (meas_fire && !hi_ok) || (err_duty_reg && !err_clr);
      err_stuck_reg  <= stuck_fire || (err_stuck_reg && !err_clr);
    end
  end

  assign period     = period_reg;
  assign high_time  = high_reg;
  assign meas_valid = meas_valid_reg;
  assign locked     = locked_reg;
  assign err_period = err_period_reg;
  assign err_duty   = err_duty_reg;
  assign err_stuck  = err_stuck_reg;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: a cycle-count reference model queues
// expected measurements, a monitor pops and compares on every meas_valid.
module tb_clk_div_monitor;

  localparam int EXP_DIV  = 6;
  localparam int EXP_HIGH = 3;
  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 2 * EXP_DIV;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             div_in = 1'b0;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err_period;
  logic             err_duty;
  logic             err_stuck;

  int errors = 0;
  int checks = 0;
  int meas_seen = 0;

  always #5 clk = ~clk;

  clk_div_monitor #(
    .EXP_DIV  (EXP_DIV),
    .EXP_HIGH (EXP_HIGH),
    .CNT_W    (CNT_W),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .div_in     (div_in),
    .err_clr    (err_clr),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err_period (err_period),
    .err_duty   (err_duty),
    .err_stuck  (err_stuck)
  );

  typedef struct {
    int per;
    int hi;
    bit lk;
    bit ep;
    bit ed;
    bit es;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: everything in terms of absolute cycle numbers.
  int cyc, last_rise_cyc, hi_len, rises, good_run;
  bit prev_in, m_lk, m_ep, m_ed, m_es;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_reset();
    cyc = 0; last_rise_cyc = 0; hi_len = 0; rises = 0; good_run = 0;
    prev_in = 1'b0; m_lk = 1'b0; m_ep = 1'b0; m_ed = 1'b0; m_es = 1'b0;
  endtask

  task automatic model_cycle(input bit v, input bit clr);
    bit   is_rise = v && !prev_in;
    bit   is_fall = !v && prev_in;
    int   since   = sat(cyc - last_rise_cyc);
    bit   sp = 1'b0, sd = 1'b0, ss = 1'b0, meas = 1'b0;
    exp_t e;
    if (is_fall) hi_len = sat(cyc - last_rise_cyc);
    if (is_rise) begin
      if (rises > 0) begin
        meas = 1'b1;
        sp = (since != EXP_DIV);
        sd = (hi_len != EXP_HIGH);
        if (sp || sd) good_run = 0;
        else if (good_run < LOCK_CNT) good_run++;
        m_lk = (good_run >= LOCK_CNT);
      end
      rises++;
      last_rise_cyc = cyc;
    end else if (since == TIMEOUT) begin
      ss = 1'b1; good_run = 0; m_lk = 1'b0; rises = 0;
    end
    m_ep = sp || (m_ep && !clr);
    m_ed = sd || (m_ed && !clr);
    m_es = ss || (m_es && !clr);
    if (meas) begin
      e.per = since; e.hi = hi_len; e.lk = m_lk; e.ep = m_ep; e.ed = m_ed; e.es = m_es;
      sb_q.push_back(e);
    end
    prev_in = v;
    cyc++;
  endtask

  task automatic step(input bit v, input bit clr);
    div_in  = v;
    err_clr = clr;
    model_cycle(v, clr);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic gen_period(input int p, input int h, input int clr_at);
    for (int i = 0; i < p; i++) step(i < h, i == clr_at);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, req);
    end
  endtask

  task automatic check_state(input string name);
    check_bit({name, ".locked"}, locked, m_lk);
    check_bit({name, ".err_period"}, err_period, m_ep);
    check_bit({name, ".err_duty"}, err_duty, m_ed);
    check_bit({name, ".err_stuck"}, err_stuck, m_es);
    $display("state %s: locked=%0b err_period=%0b err_duty=%0b err_stuck=%0b",
             name, locked, err_period, err_duty, err_stuck);
  endtask

  task automatic do_reset();
    logic [2*CNT_W+4:0] outs;
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    sb_q.delete();
    rstn = 1'b0; div_in = 1'b0; err_clr = 1'b0;
    #1;
    outs = {period, high_time, meas_valid, locked, err_period, err_duty, err_stuck};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end else begin
      $display("reset: all outputs zero");
    end
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  // Monitor: every reported measurement must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && meas_valid) begin
      checks++;
      meas_seen++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_meas: got period=%0d high=%0d expected no meas_valid",
                 period, high_time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (int'(period) != e.per || int'(high_time) != e.hi || locked !== e.lk ||
            err_period !== e.ep || err_duty !== e.ed || err_stuck !== e.es) begin
          errors++;
          $display("FAIL meas %0d: got per=%0d hi=%0d lk=%0b ep=%0b ed=%0b es=%0b expected per=%0d hi=%0d lk=%0b ep=%0b ed=%0b es=%0b",
                   meas_seen, period, high_time, locked, err_period, err_duty, err_stuck,
                   e.per, e.hi, e.lk, e.ep, e.ed, e.es);
        end else begin
          $display("meas %0d: per=%0d hi=%0d lk=%0b ep=%0b ed=%0b es=%0b ok",
                   meas_seen, period, high_time, locked, err_period, err_duty, err_stuck);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, h, c;
    model_reset();
    do_reset();

    // Ideal div-by-6, lock at the 4th measurement.
    repeat (8) gen_period(6, 3, -1);
    check_state("ideal");

    // Div-by-5 after lock, then relock with sticky err_period.
    repeat (2) gen_period(5, 3, -1);
    check_state("div5");
    repeat (6) gen_period(6, 3, -1);
    check_state("relock");

    // Clear, then 2-high/4-low duty error.
    gen_period(6, 3, 1);
    check_state("cleared");
    repeat (6) gen_period(6, 2, -1);
    check_state("duty");

    // Stuck low, then restart.
    repeat (6) gen_period(6, 3, -1);
    repeat (14) step(1'b0, 1'b0);
    check_state("stuck");
    repeat (6) gen_period(6, 3, -1);
    check_state("restart");

    // err_clr colliding with a new period mismatch, then err_clr alone.
    gen_period(6, 3, 1);
    gen_period(5, 3, -1);
    step(1'b1, 1'b1);
    check_state("clr_vs_set");
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_state("clr_alone");
    repeat (3) step(1'b0, 1'b0);

    // Randomized periods, duties (including 1-cycle glitches) and err_clr pulses.
    for (int k = 0; k < 40; k++) begin
      p = int'($urandom_range(14, 2));
      h = int'($urandom_range(p - 1, 1));
      c = ($urandom_range(5, 0) == 0) ? int'($urandom_range(p - 1, 0)) : -1;
      gen_period(p, h, c);
    end
    check_state("random");

    // Async reset mid-period while locked.
    repeat (6) gen_period(6, 3, -1);
    check_state("pre_reset");
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    do_reset();
    repeat (6) gen_period(6, 3, -1);
    check_state("post_reset");

    repeat (2) step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_final: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
